// File: rtl/alu_ctrl_seq_if.sv
// rtl/alu_ctrl_seq_if.sv - request/response handshake bundle for the ALU controller
interface alu_ctrl_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] ALUOp;
  logic       IsImm;
  logic [6:0] Funct7;
  logic [2:0] Funct3;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] Operation;
  logic       illegal;
  logic       mdu_start;
  logic       busy;

  modport master (
    output in_valid, ALUOp, IsImm, Funct7, Funct3, out_ready,
    input  in_ready, out_valid, Operation, illegal, mdu_start, busy
  );

  modport slave (
    input  in_valid, ALUOp, IsImm, Funct7, Funct3, out_ready,
    output in_ready, out_valid, Operation, illegal, mdu_start, busy
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - RV32I/M ALU op decoder with a valid/ready stage and MDU busy sequencing
module alu_ctrl_seq #(
  parameter bit ENABLE_M   = 1'b1,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  alu_ctrl_seq_if.slave bus
);
  localparam logic [4:0] OP_AND   = 5'b00000;
  localparam logic [4:0] OP_OR    = 5'b00001;
  localparam logic [4:0] OP_ADD   = 5'b00010;
  localparam logic [4:0] OP_XOR   = 5'b00011;
  localparam logic [4:0] OP_SUB   = 5'b00100;
  localparam logic [4:0] OP_SRL   = 5'b00101;
  localparam logic [4:0] OP_SLL   = 5'b00110;
  localparam logic [4:0] OP_SRA   = 5'b00111;
  localparam logic [4:0] OP_BEQ   = 5'b01000;
  localparam logic [4:0] OP_BNE   = 5'b01001;
  localparam logic [4:0] OP_BLT   = 5'b01010;
  localparam logic [4:0] OP_BGE   = 5'b01011;
  localparam logic [4:0] OP_SLT   = 5'b01100;
  localparam logic [4:0] OP_SLTU  = 5'b01101;
  localparam logic [4:0] OP_BLTU  = 5'b01110;
  localparam logic [4:0] OP_BGEU  = 5'b01111;
  localparam logic [4:0] OP_PASSB = 5'b11000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  localparam logic [7:0] MUL_LAST = 8'(MUL_CYCLES - 1);
  localparam logic [7:0] DIV_LAST = 8'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_VALID} state_t;

  state_t     state;
  logic [7:0] cnt;
  logic [4:0] dec_op;
  logic       dec_ill;
  logic       dec_m;
  logic [4:0] base_op;
  logic       accept;

  // Funct7=0000000 meaning of each Funct3, shared by R-type and I-type
  always_comb begin
    base_op = OP_ADD;
    case (bus.Funct3)
      3'b000: base_op = OP_ADD;
      3'b001: base_op = OP_SLL;
      3'b010: base_op = OP_SLT;
      3'b011: base_op = OP_SLTU;
      3'b100: base_op = OP_XOR;
      3'b101: base_op = OP_SRL;
      3'b110: base_op = OP_OR;
      3'b111: base_op = OP_AND;
    endcase
  end

  always_comb begin
    dec_op  = OP_AND;
    dec_ill = 1'b0;
    dec_m   = 1'b0;
    case (bus.ALUOp)
      2'b00: dec_op = OP_ADD;
      2'b11: dec_op = OP_PASSB;
      2'b01: begin
        case (bus.Funct3)
          3'b000:  dec_op = OP_BEQ;
          3'b001:  dec_op = OP_BNE;
          3'b100:  dec_op = OP_BLT;
          3'b101:  dec_op = OP_BGE;
          3'b110:  dec_op = OP_BLTU;
          3'b111:  dec_op = OP_BGEU;
          default: dec_ill = 1'b1;
        endcase
      end
      2'b10: begin
        if (bus.IsImm) begin
          // Only shift immediates constrain imm[11:5]
          if (bus.Funct3 != 3'b001 && bus.Funct3 != 3'b101) dec_op = base_op;
          else if (bus.Funct7 == F7_BASE) dec_op = base_op;
          else if (bus.Funct3 == 3'b101 && bus.Funct7 == F7_ALT) dec_op = OP_SRA;
          else dec_ill = 1'b1;
        end else if (bus.Funct7 == F7_BASE) begin
          dec_op = base_op;
        end else if (bus.Funct7 == F7_ALT) begin
          if (bus.Funct3 == 3'b000) dec_op = OP_SUB;
          else if (bus.Funct3 == 3'b101) dec_op = OP_SRA;
          else dec_ill = 1'b1;
        end else if (bus.Funct7 == F7_MUL && ENABLE_M) begin
          dec_op = {2'b10, bus.Funct3};
          dec_m  = 1'b1;
        end else begin
          dec_ill = 1'b1;
        end
      end
    endcase
    if (dec_ill) dec_op = OP_AND;
  end

  assign bus.in_ready = (state == S_IDLE) || (state == S_VALID && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= 8'd0;
      bus.out_valid <= 1'b0;
      bus.Operation <= OP_AND;
      bus.illegal   <= 1'b0;
      bus.mdu_start <= 1'b0;
      bus.busy      <= 1'b0;
    end else if (flush) begin
      state         <= S_IDLE;
      cnt           <= 8'd0;
      bus.out_valid <= 1'b0;
      bus.mdu_start <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_VALID: begin
          if (accept) begin
            bus.Operation <= dec_op;
            bus.illegal   <= dec_ill;
            if (dec_m) begin
              state         <= S_BUSY;
              cnt           <= bus.Funct3[2] ? DIV_LAST : MUL_LAST;
              bus.out_valid <= 1'b0;
              bus.mdu_start <= 1'b1;
              bus.busy      <= 1'b1;
            end else begin
              state         <= S_VALID;
              bus.out_valid <= 1'b1;
            end
          end else if (state == S_VALID && bus.out_ready) begin
            state         <= S_IDLE;
            bus.out_valid <= 1'b0;
          end
        end
        S_BUSY: begin
          bus.mdu_start <= 1'b0;
          if (cnt == 8'd0) begin
            state         <= S_VALID;
            bus.busy      <= 1'b0;
            bus.out_valid <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb/tb_alu_ctrl_seq.sv - randomized and directed checks of alu_ctrl_seq against a table model
module tb_alu_ctrl_seq;
  localparam int EN_M [3] = '{1, 0, 1};
  localparam int MULC [3] = '{2, 2, 1};
  localparam int DIVC [3] = '{32, 32, 3};
  localparam logic [4:0] ALU_T [8] = '{5'h02, 5'h06, 5'h0C, 5'h0D, 5'h03, 5'h05, 5'h01, 5'h00};
  localparam logic [4:0] BR_T  [8] = '{5'h08, 5'h09, 5'h00, 5'h00, 5'h0A, 5'h0B, 5'h0E, 5'h0F};

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic in_valid, out_ready, IsImm;
  logic [1:0] ALUOp;
  logic [6:0] Funct7;
  logic [2:0] Funct3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_ctrl_seq_if if0 ();
  alu_ctrl_seq_if if1 ();
  alu_ctrl_seq_if if2 ();

  assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;  assign if2.in_valid = in_valid;
  assign if0.out_ready = out_ready; assign if1.out_ready = out_ready; assign if2.out_ready = out_ready;
  assign if0.ALUOp = ALUOp;   assign if1.ALUOp = ALUOp;   assign if2.ALUOp = ALUOp;
  assign if0.IsImm = IsImm;   assign if1.IsImm = IsImm;   assign if2.IsImm = IsImm;
  assign if0.Funct7 = Funct7; assign if1.Funct7 = Funct7; assign if2.Funct7 = Funct7;
  assign if0.Funct3 = Funct3; assign if1.Funct3 = Funct3; assign if2.Funct3 = Funct3;

  alu_ctrl_seq #(.ENABLE_M(1'b1), .MUL_CYCLES(2), .DIV_CYCLES(32)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if0));
  alu_ctrl_seq #(.ENABLE_M(1'b0), .MUL_CYCLES(2), .DIV_CYCLES(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if1));
  alu_ctrl_seq #(.ENABLE_M(1'b1), .MUL_CYCLES(1), .DIV_CYCLES(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if2));

  logic [2:0] ov, ms, bs, ir, il;
  logic [4:0] opv [3];
  assign ov = {if2.out_valid, if1.out_valid, if0.out_valid};
  assign ms = {if2.mdu_start, if1.mdu_start, if0.mdu_start};
  assign bs = {if2.busy, if1.busy, if0.busy};
  assign ir = {if2.in_ready, if1.in_ready, if0.in_ready};
  assign il = {if2.illegal, if1.illegal, if0.illegal};
  assign opv[0] = if0.Operation;
  assign opv[1] = if1.Operation;
  assign opv[2] = if2.Operation;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns {illegal, operation} from the instruction-set rules
  function automatic logic [5:0] model(input int en_m, input logic [1:0] aop, input logic imm,
                                       input logic [6:0] f7, input logic [2:0] f3);
    logic [4:0] op;
    logic ill;
    bit shift;
    ill   = 1'b0;
    op    = 5'h00;
    shift = (f3 == 3'd1) || (f3 == 3'd5);
    if (aop == 2'd0) op = 5'h02;
    else if (aop == 2'd3) op = 5'h18;
    else if (aop == 2'd1) begin
      if (f3 == 3'd2 || f3 == 3'd3) ill = 1'b1;
      else op = BR_T[f3];
    end else if (imm) begin
      if (!shift || f7 == 7'h00) op = ALU_T[f3];
      else if (f3 == 3'd5 && f7 == 7'h20) op = 5'h07;
      else ill = 1'b1;
    end else begin
      if (f7 == 7'h00) op = ALU_T[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) op = 5'h04;
      else if (f7 == 7'h20 && f3 == 3'd5) op = 5'h07;
      else if (f7 == 7'h01 && en_m != 0) op = {2'b10, f3};
      else ill = 1'b1;
    end
    if (ill) op = 5'h00;
    return {ill, op};
  endfunction

  function automatic int mdu_cycles(input int d, input logic [1:0] aop, input logic imm,
                                    input logic [6:0] f7, input logic [2:0] f3);
    if (EN_M[d] != 0 && aop == 2'd2 && !imm && f7 == 7'h01)
      return f3[2] ? DIVC[d] : MULC[d];
    return 0;
  endfunction

  task automatic do_req(input logic [1:0] aop, input logic imm, input logic [6:0] f7,
                        input logic [2:0] f3, input int stall);
    logic [5:0] exp [3];
    int nexp [3];
    int first [3];
    int mdu_n [3];
    int busy_n [3];
    bit done;
    logic [4:0] held;
    for (int d = 0; d < 3; d++) begin
      exp[d]    = model(EN_M[d], aop, imm, f7, f3);
      nexp[d]   = mdu_cycles(d, aop, imm, f7, f3);
      first[d]  = -1;
      mdu_n[d]  = 0;
      busy_n[d] = 0;
    end
    ALUOp = aop; IsImm = imm; Funct7 = f7; Funct3 = f3;
    in_valid = 1'b1;
    out_ready = 1'b0;
    check("in_ready_idle", 32'(ir), 32'h7);
    step();
    in_valid = 1'b0;
    done = 1'b0;
    for (int idx = 0; idx < 64 && !done; idx++) begin
      done = 1'b1;
      for (int d = 0; d < 3; d++) begin
        if (ms[d]) mdu_n[d]++;
        if (bs[d]) busy_n[d]++;
        if (first[d] < 0) begin
          if (ov[d]) first[d] = idx;
          else done = 1'b0;
        end
      end
      if (!done) step();
    end
    for (int d = 0; d < 3; d++) begin
      check($sformatf("latency_dut%0d", d), 32'(first[d]), 32'(nexp[d]));
      check($sformatf("op_dut%0d", d), 32'(opv[d]), 32'(exp[d][4:0]));
      check($sformatf("illegal_dut%0d", d), 32'(il[d]), 32'(exp[d][5]));
      check($sformatf("mdu_pulses_dut%0d", d), 32'(mdu_n[d]), (nexp[d] > 0) ? 32'd1 : 32'd0);
      check($sformatf("busy_cycles_dut%0d", d), 32'(busy_n[d]), 32'(nexp[d]));
    end
    held = opv[0];
    for (int s = 0; s < stall; s++) begin
      step();
      check("stall_op_stable", 32'(opv[0]), 32'(held));
      check("stall_in_ready", 32'(ir[0]), 32'd0);
      check("stall_valid", 32'(ov[0]), 32'd1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("drained", 32'(ov), 32'd0);
  endtask

  logic [2:0] br_f3 [7];
  logic [5:0] br_exp [7];
  int cnt_ms, cnt_ov;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ALUOp = 2'd0; IsImm = 1'b0; Funct7 = 7'd0; Funct3 = 3'd0;
    step();
    check("rst_in_ready", 32'(ir), 32'h7);
    check("rst_out_valid", 32'(ov), 32'h0);
    check("rst_op", 32'(opv[0]), 32'h0);
    check("rst_illegal", 32'(il), 32'h0);
    check("rst_mdu_start", 32'(ms), 32'h0);
    check("rst_busy", 32'(bs), 32'h0);
    step();
    rst_n = 1'b1;
    step();

    do_req(2'b10, 1'b0, 7'h20, 3'b000, 3);   // SUB, stalled 3 cycles
    do_req(2'b10, 1'b1, 7'h20, 3'b000, 0);   // ADDI with imm[11:5]=0100000
    do_req(2'b10, 1'b1, 7'h20, 3'b101, 0);   // SRAI
    do_req(2'b10, 1'b1, 7'h20, 3'b001, 0);   // SLLI bad imm
    do_req(2'b10, 1'b0, 7'h01, 3'b100, 1);   // DIV
    do_req(2'b10, 1'b0, 7'h01, 3'b000, 0);   // MUL, N=1 on dut2
    do_req(2'b11, 1'b0, 7'h00, 3'b000, 0);   // PASSB
    do_req(2'b00, 1'b0, 7'h00, 3'b000, 0);   // ADD

    br_f3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2};
    br_exp = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0E, 6'h0F, 6'h20};
    ALUOp = 2'b01; IsImm = 1'b0; Funct7 = 7'd0;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      Funct3 = br_f3[i];
      in_valid = 1'b1;
      check("b2b_in_ready", 32'(ir[0]), 32'd1);
      step();
      check("b2b_valid", 32'(ov[0]), 32'd1);
      check("b2b_op", 32'({il[0], opv[0]}), 32'(br_exp[i]));
    end
    in_valid = 1'b0;
    step();
    check("b2b_idle", 32'(ov), 32'd0);
    out_ready = 1'b0;

    ALUOp = 2'b10; IsImm = 1'b0; Funct7 = 7'h01; Funct3 = 3'b000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("flush_pre_busy", 32'(bs[0]), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_busy", 32'(bs), 32'd0);
    check("flush_in_ready", 32'(ir[0]), 32'd1);
    cnt_ov = 0;
    for (int i = 0; i < 4; i++) begin
      if (ov[0]) cnt_ov++;
      step();
    end
    check("flush_no_valid", 32'(cnt_ov), 32'd0);
    ALUOp = 2'b00; in_valid = 1'b1; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    check("flush_blocks_accept", 32'(ov), 32'd0);

    ALUOp = 2'b10; Funct7 = 7'h01; Funct3 = 3'b101;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("rst_pre_busy", 32'(bs[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(bs[0]), 32'd0);
    check("arst_mdu", 32'(ms[0]), 32'd0);
    check("arst_valid", 32'(ov[0]), 32'd0);
    check("arst_op", 32'({il[0], opv[0]}), 32'd0);
    check("arst_in_ready", 32'(ir[0]), 32'd1);
    step();
    step();
    rst_n = 1'b1;
    cnt_ms = 0; cnt_ov = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ms[0]) cnt_ms++;
      if (ov[0]) cnt_ov++;
    end
    check("post_rst_no_mdu", 32'(cnt_ms), 32'd0);
    check("post_rst_no_valid", 32'(cnt_ov), 32'd0);

    for (int n = 0; n < 40; n++) begin
      logic [1:0] aop;
      logic imm;
      logic [6:0] f7;
      logic [2:0] f3;
      int sel;
      aop = 2'($urandom_range(0, 3));
      imm = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 3);
      f7  = (sel == 0) ? 7'h00 : (sel == 1) ? 7'h20 : (sel == 2) ? 7'h01 : 7'($urandom);
      f3  = 3'($urandom);
      do_req(aop, imm, f7, f3, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
